pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter TIMEOUT, default 16'hFFFF, cycles without a rising edge before a stuck-level report.
REQ-002 Clock  input  1  system clock; all state updates on posedge Clock.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 PwmIn  input  1  asynchronous PWM waveform to be measured.
REQ-005 Period  output  16  last measured period in Clock cycles (rise to rise); 0 on stuck-level report.
REQ-006 HighTime  output  16  last measured high time in Clock cycles within that period.
REQ-007 Duty  output  8  duty estimate: HighTime saturated to 255; stuck report gives 0 (low) or 255 (high).
REQ-008 Valid  output  1  one-cycle pulse; Period/HighTime/Duty/Locked updated in the same cycle.
REQ-009 Locked  output  1  1 when the last report had Period == 256, i.e. an 8-bit free-running PWM frame.
REQ-010 Stuck  output  1  1 when the last report was a timeout (no edge), 0 after any edge-based report.

Function
REQ-011 PwmIn SHALL pass through a 2-flop synchronizer (S1, S2); S3 SHALL hold the previous S2; Rise = S2 & ~S3.
REQ-012 Rise SHALL occur 3 Clock edges after a PwmIn low-to-high transition that meets setup; all counting uses S2 only.
REQ-013 FSM states: WAIT_EDGE (no reference edge yet) and MEASURE (counting since last Rise).
REQ-014 WAIT_EDGE: PerCnt increments each cycle; on Rise -> MEASURE with PerCnt=1, HighCnt=1; no report.
REQ-015 MEASURE, no Rise: PerCnt += 1; HighCnt += S2.
REQ-016 MEASURE, Rise: register Period=PerCnt, HighTime=HighCnt, Valid=1 next edge; reload PerCnt=1, HighCnt=1; stay MEASURE.
REQ-017 Rise cycle SHALL count as cycle 1 of the new period; a 256-cycle PWM with duty D (1..255) reports Period=256, HighTime=D.
REQ-018 Duty = HighTime[7:0] if HighTime <= 255, else 8'd255; Locked = (Period == 16'd256); Stuck = 0 on edge reports.
REQ-019 Timeout: when PerCnt == TIMEOUT and no Rise in that cycle (either state), SHALL report Period=0, HighTime=0, Duty = S2 ? 255 : 0, Locked=0, Stuck=1, Valid=1, then go to WAIT_EDGE with PerCnt=0.
REQ-020 Rise and PerCnt == TIMEOUT in the same cycle: Rise wins (REQ-014/016); no timeout report.
REQ-021 PerCnt and HighCnt SHALL never wrap; timeout fires before 16-bit overflow.
REQ-022 Outputs other than Valid SHALL hold their last value between reports.
REQ-023 First Rise after reset or after a timeout SHALL never produce a report (only establishes the reference edge).

Reset
REQ-024 Reset asserted SHALL immediately force: state WAIT_EDGE, S1=S2=S3=0, PerCnt=0, HighCnt=0, Period=0, HighTime=0, Duty=0, Valid=0, Locked=0, Stuck=0.
REQ-025 Reset mid-measurement SHALL discard partial counts; no Valid pulse during or on release of Reset.
REQ-026 After release, a high PwmIn SHALL produce a Rise (S3 resets to 0) and be treated as the first edge.

Verification
REQ-027 256-cycle PWM, D=128, three periods -> first Rise no report; then Valid every 256 cycles with Period=256, HighTime=128, Duty=128, Locked=1, Stuck=0.
REQ-028 256-cycle PWM, D=1 then D=255 -> Duty=1 then Duty=255, Period=256, Locked=1; change visible on the report after the first full new-duty period.
REQ-029 Period 1000, high 600 -> Period=1000, HighTime=600, Duty=255, Locked=0.
REQ-030 PwmIn held high after MEASURE (TIMEOUT=16'd300 override) -> Valid once with Period=0, Duty=255, Stuck=1; no further Valid until next Rise+full period.
REQ-031 Reset pulsed at cycle 100 of a 256-cycle period -> all outputs 0 at once; first report only after second post-reset Rise.
REQ-032 Rise coinciding with PerCnt == TIMEOUT -> edge report with Period=TIMEOUT, Stuck=0; no timeout pulse.

Source files
------------

// File: rtl/pwm_capture_if.sv
// Signal bundle for the PWM capture block: the measured waveform going in and
// the measurement report coming out.
interface pwm_capture_if;
    logic        PwmIn;
    logic [15:0] Period;
    logic [15:0] HighTime;
    logic [7:0]  Duty;
    logic        Valid;
    logic        Locked;
    logic        Stuck;

    modport master (
        output PwmIn,
        input  Period, HighTime, Duty, Valid, Locked, Stuck
    );

    modport slave (
        input  PwmIn,
        output Period, HighTime, Duty, Valid, Locked, Stuck
    );
endinterface

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input between rising
// edges, and reports a stuck level when no edge arrives within TIMEOUT cycles.
module pwm_capture #(
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input logic          Clock,
    input logic          Reset,
    pwm_capture_if.slave bus
);

    localparam logic [0:0] WAIT_EDGE = 1'b0;
    localparam logic [0:0] MEASURE   = 1'b1;

    logic        s1_q, s2_q, s3_q;
    logic        rise;
    logic [0:0]  state_q, state_d;
    logic [15:0] perCnt_q, perCnt_d;
    logic [15:0] highCnt_q, highCnt_d;
    logic [15:0] period_q, period_d;
    logic [15:0] highTime_q, highTime_d;
    logic [7:0]  duty_q, duty_d;
    logic        valid_q, valid_d;
    logic        locked_q, locked_d;
    logic        stuck_q, stuck_d;

    assign rise = s2_q & ~s3_q;

    // A rise always wins over a coincident timeout; the rise cycle counts as cycle 1.
    always_comb begin
        state_d    = state_q;
        perCnt_d   = perCnt_q;
        highCnt_d  = highCnt_q;
        period_d   = period_q;
        highTime_d = highTime_q;
        duty_d     = duty_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        stuck_d    = stuck_q;

        if (rise) begin
            if (state_q == MEASURE) begin
                period_d   = perCnt_q;
                highTime_d = highCnt_q;
                duty_d     = (highCnt_q > 16'd255) ? 8'hFF : highCnt_q[7:0];
                locked_d   = (perCnt_q == 16'd256);
                stuck_d    = 1'b0;
                valid_d    = 1'b1;
            end
            state_d   = MEASURE;
            perCnt_d  = 16'd1;
            highCnt_d = 16'd1;
        end else if (perCnt_q == TIMEOUT) begin
            period_d   = 16'd0;
            highTime_d = 16'd0;
            duty_d     = s2_q ? 8'hFF : 8'h00;
            locked_d   = 1'b0;
            stuck_d    = 1'b1;
            valid_d    = 1'b1;
            state_d    = WAIT_EDGE;
            perCnt_d   = 16'd0;
            highCnt_d  = 16'd0;
        end else begin
            perCnt_d = perCnt_q + 16'd1;
            if (state_q == MEASURE) begin
                highCnt_d = highCnt_q + {15'd0, s2_q};
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            state_q    <= WAIT_EDGE;
            perCnt_q   <= 16'd0;
            highCnt_q  <= 16'd0;
            period_q   <= 16'd0;
            highTime_q <= 16'd0;
            duty_q     <= 8'd0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            s1_q       <= bus.PwmIn;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            state_q    <= state_d;
            perCnt_q   <= perCnt_d;
            highCnt_q  <= highCnt_d;
            period_q   <= period_d;
            highTime_q <= highTime_d;
            duty_q     <= duty_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            stuck_q    <= stuck_d;
        end
    end

    assign bus.Period   = period_q;
    assign bus.HighTime = highTime_q;
    assign bus.Duty     = duty_q;
    assign bus.Valid    = valid_q;
    assign bus.Locked   = locked_q;
    assign bus.Stuck    = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: two instances (default and short timeout) driven by
// the same waveform and compared every cycle against an edge-timestamp model.
module tb_pwm_capture;

    localparam int MAXC = 40000;

    logic Clock;
    logic Reset;
    logic pwm;

    pwm_capture_if ifA ();
    pwm_capture_if ifB ();

    assign ifA.PwmIn = pwm;
    assign ifB.PwmIn = pwm;

    pwm_capture dutA (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (ifA)
    );

    pwm_capture #(.TIMEOUT(16'd300)) dutB (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (ifB)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    bit          lvl [MAXC];
    int          cyc;
    int          rEdge;
    bit          rstHeld;
    int          base [2];
    int          prevRise [2];
    bit          havRef [2];
    int          tmo [2];
    logic        eV [2];
    logic        eL [2];
    logic        eS [2];
    logic [15:0] eP [2];
    logic [15:0] eH [2];
    logic [7:0]  eD [2];
    int          vCnt [2];
    int          checks;
    int          errors;

    // Level seen by the measurement logic; synchronizer contents before release read as low.
    function automatic bit syncLevel(int j);
        if (j < rEdge || j < 0) return 1'b0;
        return lvl[j];
    endfunction

    task automatic clearExpect();
        for (int d = 0; d < 2; d++) begin
            eV[d] = 1'b0; eL[d] = 1'b0; eS[d] = 1'b0;
            eP[d] = 16'd0; eH[d] = 16'd0; eD[d] = 8'd0;
        end
    endtask

    // Reports are derived from rise timestamps and the count of high samples between them.
    task automatic modelEdge();
        int pc;
        int hs;
        bit rise;
        if (Reset) begin
            rstHeld = 1'b1;
            clearExpect();
            return;
        end
        if (rstHeld) begin
            rstHeld = 1'b0;
            rEdge = cyc;
            for (int d = 0; d < 2; d++) begin
                base[d] = cyc;
                havRef[d] = 1'b0;
            end
        end
        rise = syncLevel(cyc - 2) && !syncLevel(cyc - 3);
        for (int d = 0; d < 2; d++) begin
            eV[d] = 1'b0;
            pc = cyc - base[d];
            if (rise) begin
                if (havRef[d]) begin
                    hs = 0;
                    for (int j = prevRise[d] - 2; j <= cyc - 3; j++) hs += int'(syncLevel(j));
                    eP[d] = 16'(pc);
                    eH[d] = 16'(hs);
                    eD[d] = (hs > 255) ? 8'd255 : 8'(hs);
                    eL[d] = (pc == 256);
                    eS[d] = 1'b0;
                    eV[d] = 1'b1;
                end
                havRef[d] = 1'b1;
                prevRise[d] = cyc;
                base[d] = cyc;
            end else if (pc == tmo[d]) begin
                eP[d] = 16'd0;
                eH[d] = 16'd0;
                eD[d] = syncLevel(cyc - 2) ? 8'd255 : 8'd0;
                eL[d] = 1'b0;
                eS[d] = 1'b1;
                eV[d] = 1'b1;
                havRef[d] = 1'b0;
                base[d] = cyc + 1;
            end
        end
    endtask

    task automatic runCycle(input bit v);
        logic [42:0] got;
        logic [42:0] exp;
        if (cyc + 2 >= MAXC) begin
            $display("[TB] FAIL cycle_budget: got cycle %0d, limit %0d", cyc, MAXC);
            errors++;
            $fatal(1, "[TB] cycle budget exhausted");
        end
        pwm = v;
        lvl[cyc + 1] = v;
        @(posedge Clock);
        cyc++;
        modelEdge();
        @(negedge Clock);
        for (int d = 0; d < 2; d++) begin
            got = (d == 0) ? {ifA.Valid, ifA.Period, ifA.HighTime, ifA.Duty, ifA.Locked, ifA.Stuck}
                           : {ifB.Valid, ifB.Period, ifB.HighTime, ifB.Duty, ifB.Locked, ifB.Stuck};
            exp = {eV[d], eP[d], eH[d], eD[d], eL[d], eS[d]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL outputs dut%0d cycle %0d: got {V,P,H,D,L,S}=%h expected %h",
                         d, cyc, got, exp);
            end
            if (got[42] === 1'b1) vCnt[d]++;
        end
    endtask

    task automatic runPwm(input int period, input int high, input int frames);
        for (int f = 0; f < frames; f++)
            for (int i = 0; i < period; i++) runCycle(i < high);
    endtask

    task automatic doReset(input int n, input bit level);
        Reset = 1'b1;
        #1;
        clearExpect();
        checks++;
        if ({ifA.Period, ifA.HighTime, ifA.Duty, ifA.Valid, ifA.Locked, ifA.Stuck} !== 43'd0) begin
            errors++;
            $display("[TB] FAIL reset_immediate_A: got P%0d H%0d D%0d V%0b L%0b S%0b expected all 0",
                     ifA.Period, ifA.HighTime, ifA.Duty, ifA.Valid, ifA.Locked, ifA.Stuck);
        end
        checks++;
        if ({ifB.Period, ifB.HighTime, ifB.Duty, ifB.Valid, ifB.Locked, ifB.Stuck} !== 43'd0) begin
            errors++;
            $display("[TB] FAIL reset_immediate_B: got P%0d H%0d D%0d V%0b L%0b S%0b expected all 0",
                     ifB.Period, ifB.HighTime, ifB.Duty, ifB.Valid, ifB.Locked, ifB.Stuck);
        end
        repeat (n) runCycle(level);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset(3, 1'b0);
        repeat (5) runCycle(1'b0);
        checks++;
        if (vCnt[0] + vCnt[1] !== 0) begin
            errors++;
            $display("[TB] FAIL reset_no_valid: got %0d pulses expected 0", vCnt[0] + vCnt[1]);
        end
    endtask

    task automatic test_duty128();
        int s;
        s = vCnt[0];
        runPwm(256, 128, 4);
        checks++;
        if (vCnt[0] - s !== 3) begin
            errors++; $display("[TB] FAIL d128_count: got %0d expected 3", vCnt[0] - s);
        end
        checks++;
        if (ifA.Period !== 16'd256) begin
            errors++; $display("[TB] FAIL d128_period: got %0d expected 256", ifA.Period);
        end
        checks++;
        if (ifA.HighTime !== 16'd128) begin
            errors++; $display("[TB] FAIL d128_high: got %0d expected 128", ifA.HighTime);
        end
        checks++;
        if (ifA.Duty !== 8'd128) begin
            errors++; $display("[TB] FAIL d128_duty: got %0d expected 128", ifA.Duty);
        end
        checks++;
        if (ifA.Locked !== 1'b1 || ifA.Stuck !== 1'b0) begin
            errors++; $display("[TB] FAIL d128_flags: got L%0b S%0b expected L1 S0", ifA.Locked, ifA.Stuck);
        end
    endtask

    task automatic test_duty_extremes();
        runPwm(256, 1, 3);
        checks++;
        if (ifA.Duty !== 8'd1 || ifA.HighTime !== 16'd1) begin
            errors++; $display("[TB] FAIL d1_duty: got D%0d H%0d expected D1 H1", ifA.Duty, ifA.HighTime);
        end
        runPwm(256, 255, 1);
        checks++;
        if (ifA.Duty !== 8'd1) begin
            errors++; $display("[TB] FAIL d255_first_report: got %0d expected 1", ifA.Duty);
        end
        runPwm(256, 255, 2);
        checks++;
        if (ifA.Duty !== 8'd255 || ifA.Locked !== 1'b1 || ifA.Period !== 16'd256) begin
            errors++;
            $display("[TB] FAIL d255_duty: got D%0d L%0b P%0d expected D255 L1 P256",
                     ifA.Duty, ifA.Locked, ifA.Period);
        end
    endtask

    task automatic test_long_period();
        runPwm(1000, 600, 3);
        checks++;
        if (ifA.Period !== 16'd1000 || ifA.HighTime !== 16'd600) begin
            errors++;
            $display("[TB] FAIL long_counts: got P%0d H%0d expected P1000 H600", ifA.Period, ifA.HighTime);
        end
        checks++;
        if (ifA.Duty !== 8'd255 || ifA.Locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL long_duty: got D%0d L%0b expected D255 L0", ifA.Duty, ifA.Locked);
        end
    endtask

    task automatic test_stuck_high();
        int s;
        runPwm(256, 100, 2);
        s = vCnt[1];
        repeat (400) runCycle(1'b1);
        checks++;
        if (vCnt[1] - s !== 2) begin
            errors++; $display("[TB] FAIL stuck_count: got %0d expected 2", vCnt[1] - s);
        end
        checks++;
        if (ifB.Period !== 16'd0 || ifB.HighTime !== 16'd0 || ifB.Duty !== 8'd255 ||
            ifB.Stuck !== 1'b1 || ifB.Locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stuck_report: got P%0d H%0d D%0d S%0b L%0b expected P0 H0 D255 S1 L0",
                     ifB.Period, ifB.HighTime, ifB.Duty, ifB.Stuck, ifB.Locked);
        end
        repeat (20) runCycle(1'b0);
        s = vCnt[1];
        runPwm(256, 100, 1);
        checks++;
        if (vCnt[1] - s !== 0) begin
            errors++; $display("[TB] FAIL stuck_first_rise: got %0d pulses expected 0", vCnt[1] - s);
        end
        runPwm(256, 100, 1);
        checks++;
        if (vCnt[1] - s !== 1 || ifB.Period !== 16'd256 || ifB.Stuck !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stuck_recover: got n%0d P%0d S%0b expected n1 P256 S0",
                     vCnt[1] - s, ifB.Period, ifB.Stuck);
        end
    endtask

    task automatic test_reset_mid();
        int s;
        runPwm(256, 128, 2);
        repeat (100) runCycle(1'b1);
        doReset(3, 1'b1);
        s = vCnt[0];
        repeat (28) runCycle(1'b1);
        repeat (128) runCycle(1'b0);
        checks++;
        if (vCnt[0] - s !== 0) begin
            errors++; $display("[TB] FAIL rstmid_first_edge: got %0d pulses expected 0", vCnt[0] - s);
        end
        runPwm(256, 128, 2);
        checks++;
        if (vCnt[0] - s !== 2 || ifA.Period !== 16'd256) begin
            errors++;
            $display("[TB] FAIL rstmid_resume: got n%0d P%0d expected n2 P256", vCnt[0] - s, ifA.Period);
        end
    endtask

    task automatic test_timeout_boundary();
        int s;
        s = vCnt[1];
        runPwm(300, 50, 3);
        checks++;
        if (vCnt[1] - s !== 3 || ifB.Period !== 16'd300 || ifB.Stuck !== 1'b0) begin
            errors++;
            $display("[TB] FAIL edge_at_timeout: got n%0d P%0d S%0b expected n3 P300 S0",
                     vCnt[1] - s, ifB.Period, ifB.Stuck);
        end
        s = vCnt[1];
        runPwm(301, 50, 2);
        checks++;
        if (vCnt[1] - s !== 2 || ifB.Stuck !== 1'b1 || ifB.Duty !== 8'd0 || ifB.Period !== 16'd0) begin
            errors++;
            $display("[TB] FAIL past_timeout: got n%0d S%0b D%0d P%0d expected n2 S1 D0 P0",
                     vCnt[1] - s, ifB.Stuck, ifB.Duty, ifB.Period);
        end
    endtask

    task automatic test_random();
        int p, h, prevP, prevH;
        prevP = 0;
        prevH = 0;
        for (int f = 0; f < 15; f++) begin
            prevP = p;
            prevH = h;
            p = int'($urandom_range(700, 20));
            h = int'($urandom_range(p - 1, 1));
            runPwm(p, h, 1);
        end
        checks++;
        if (ifA.Period !== 16'(prevP) || ifA.HighTime !== 16'(prevH)) begin
            errors++;
            $display("[TB] FAIL random_last: got P%0d H%0d expected P%0d H%0d",
                     ifA.Period, ifA.HighTime, prevP, prevH);
        end
    endtask

    initial begin
        Reset = 1'b1;
        pwm = 1'b0;
        cyc = 0;
        rEdge = 0;
        rstHeld = 1'b1;
        tmo[0] = 65535;
        tmo[1] = 300;
        vCnt[0] = 0;
        vCnt[1] = 0;
        checks = 0;
        errors = 0;
        for (int d = 0; d < 2; d++) begin
            base[d] = 0; prevRise[d] = 0; havRef[d] = 1'b0;
        end
        clearExpect();
        @(negedge Clock);
        test_reset();
        test_duty128();
        test_duty_extremes();
        test_long_period();
        test_stuck_high();
        test_reset_mid();
        test_timeout_boundary();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
